// File: rtl/seg7_capture.sv
// Reads back four active-low seven-segment buses into a 16-bit value once the
// display has been stable for STABLE_CYCLES edges; reports lock, fault and bad digits.
module seg7_capture #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic        clock,
  input  logic        clear,
  input  logic [6:0]  HEX0,
  input  logic [6:0]  HEX1,
  input  logic [6:0]  HEX2,
  input  logic [6:0]  HEX3,
  output logic [15:0] value,
  output logic        locked,
  output logic        fault,
  output logic [3:0]  bad_digit,
  output logic        update
);

  typedef enum logic [1:0] {
    SETTLING,
    LOCKED,
    FAULT
  } state_t;

  localparam logic [7:0]  RUN_MAX  = 8'(STABLE_CYCLES);
  localparam logic [27:0] SNAP_RST = {4{7'h7F}};

  // Returns {invalid, nibble}; only exact segment patterns decode.
  function automatic logic [4:0] decode_seg(input logic [6:0] seg);
    case (seg)
      7'h40:   return 5'h00;
      7'h79:   return 5'h01;
      7'h24:   return 5'h02;
      7'h30:   return 5'h03;
      7'h19:   return 5'h04;
      7'h12:   return 5'h05;
      7'h02:   return 5'h06;
      7'h78:   return 5'h07;
      7'h00:   return 5'h08;
      7'h10:   return 5'h09;
      7'h08:   return 5'h0A;
      7'h03:   return 5'h0B;
      7'h46:   return 5'h0C;
      7'h21:   return 5'h0D;
      7'h06:   return 5'h0E;
      7'h0E:   return 5'h0F;
      default: return 5'h10;
    endcase
  endfunction

  logic [27:0] cur;
  logic        same;
  logic        eval;
  logic [15:0] dec_val;
  logic [3:0]  dec_bad;

  state_t      state_q,  state_d;
  logic [27:0] snap_q,   snap_d;
  logic [7:0]  run_q,    run_d;
  logic [15:0] value_q,  value_d;
  logic        locked_q, locked_d;
  logic        fault_q,  fault_d;
  logic [3:0]  bad_q,    bad_d;
  logic        update_q, update_d;
  logic        first_q,  first_d;

  assign cur  = {HEX3, HEX2, HEX1, HEX0};
  assign same = (cur == snap_q);
  // Fires only on the edge the run count reaches its limit, never while saturated.
  assign eval = same && (run_q == RUN_MAX - 8'd1);

  always_comb begin
    logic [4:0] dec;
    dec     = '0;
    dec_val = '0;
    dec_bad = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      dec                = decode_seg(cur[7*i +: 7]);
      dec_val[4*i +: 4]  = dec[3:0];
      dec_bad[i]         = dec[4];
    end
  end

  always_comb begin
    snap_d   = cur;
    state_d  = state_q;
    value_d  = value_q;
    locked_d = locked_q;
    fault_d  = fault_q;
    bad_d    = bad_q;
    update_d = 1'b0;
    first_d  = first_q;

    if (!same)                run_d = '0;
    else if (run_q >= RUN_MAX) run_d = RUN_MAX;
    else                      run_d = run_q + 8'd1;

    if (!same) begin
      state_d  = SETTLING;
      locked_d = 1'b0;
      fault_d  = 1'b0;
    end else if (state_q == SETTLING && eval) begin
      if (dec_bad == '0) begin
        state_d  = LOCKED;
        locked_d = 1'b1;
        bad_d    = '0;
        value_d  = dec_val;
        update_d = first_q || (dec_val != value_q);
        first_d  = 1'b0;
      end else begin
        state_d  = FAULT;
        fault_d  = 1'b1;
        bad_d    = dec_bad;
      end
    end
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q  <= SETTLING;
      snap_q   <= SNAP_RST;
      run_q    <= '0;
      value_q  <= '0;
      locked_q <= 1'b0;
      fault_q  <= 1'b0;
      bad_q    <= '0;
      update_q <= 1'b0;
      first_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      snap_q   <= snap_d;
      run_q    <= run_d;
      value_q  <= value_d;
      locked_q <= locked_d;
      fault_q  <= fault_d;
      bad_q    <= bad_d;
      update_q <= update_d;
      first_q  <= first_d;
    end
  end

  assign value     = value_q;
  assign locked    = locked_q;
  assign fault     = fault_q;
  assign bad_digit = bad_q;
  assign update    = update_q;

endmodule

// File: tb/tb_seg7_capture.sv
// Directed and randomized checks of seg7_capture against a history-queue reference model.
module tb_seg7_capture;

  localparam int S = 4;

  logic        clock = 1'b0;
  logic        clear;
  logic [6:0]  HEX0, HEX1, HEX2, HEX3;
  logic [15:0] value;
  logic        locked, fault, update;
  logic [3:0]  bad_digit;

  seg7_capture #(.STABLE_CYCLES(S)) dut (
    .clock(clock), .clear(clear),
    .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3),
    .value(value), .locked(locked), .fault(fault),
    .bad_digit(bad_digit), .update(update)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Reference model: input history per edge plus expected outputs.
  logic [27:0] hist [$];
  logic [15:0] m_value;
  logic        m_locked, m_fault, m_update, m_first;
  logic [3:0]  m_bad;

  function automatic int seg_to_nib(input logic [6:0] s);
    for (int i = 0; i < 16; i++) if (seg_tab[i] == s) return i;
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    hist.push_back({4{7'h7F}});
    m_value = '0; m_locked = 0; m_fault = 0; m_update = 0; m_bad = '0; m_first = 1;
  endtask

  task automatic model_edge(input logic [27:0] cur);
    logic [27:0] prev;
    int          stable_len, n;
    logic [15:0] dv;
    logic [3:0]  mask;
    prev = hist[hist.size()-1];
    hist.push_back(cur);
    if (hist.size() > S + 3) void'(hist.pop_front());
    stable_len = 0;
    for (int i = hist.size() - 1; i >= 0; i--) begin
      if (hist[i] != cur) break;
      stable_len++;
    end
    m_update = 0;
    if (cur != prev) begin
      m_locked = 0;
      m_fault  = 0;
    end else if (stable_len == S + 1) begin
      dv = '0; mask = '0;
      for (int d = 0; d < 4; d++) begin
        n = seg_to_nib(cur[7*d +: 7]);
        if (n < 0) mask[d] = 1'b1;
        else       dv[4*d +: 4] = n[3:0];
      end
      if (mask == 0) begin
        m_update = m_first || (dv != m_value);
        m_value  = dv;
        m_locked = 1; m_fault = 0; m_bad = '0; m_first = 0;
      end else begin
        m_fault = 1; m_locked = 0; m_bad = mask;
      end
    end
  endtask

  task automatic check_outputs(input string where);
    chk({where, ".value"},     32'(value),     32'(m_value));
    chk({where, ".locked"},    32'(locked),    32'(m_locked));
    chk({where, ".fault"},     32'(fault),     32'(m_fault));
    chk({where, ".bad_digit"}, 32'(bad_digit), 32'(m_bad));
    chk({where, ".update"},    32'(update),    32'(m_update));
  endtask

  task automatic step(input logic [27:0] pat, input string where);
    {HEX3, HEX2, HEX1, HEX0} = pat;
    @(posedge clock);
    model_edge(pat);
    #1;
    check_outputs(where);
  endtask

  task automatic check_reset_zero(input string where);
    chk({where, ".value"},     32'(value),     32'h0);
    chk({where, ".locked"},    32'(locked),    32'h0);
    chk({where, ".fault"},     32'(fault),     32'h0);
    chk({where, ".bad_digit"}, 32'(bad_digit), 32'h0);
    chk({where, ".update"},    32'(update),    32'h0);
  endtask

  localparam logic [27:0] P7654 = {7'h78, 7'h02, 7'h12, 7'h19};
  localparam logic [27:0] P7650 = {7'h78, 7'h02, 7'h12, 7'h40};
  localparam logic [27:0] PBLNK = {7'h78, 7'h02, 7'h7F, 7'h40};
  localparam logic [27:0] P7250 = {7'h78, 7'h24, 7'h12, 7'h40};
  localparam logic [27:0] P8888 = 28'h0;

  initial begin
    logic [27:0] pat, keep;
    int          hold, r;

    clear = 1'b0;
    {HEX3, HEX2, HEX1, HEX0} = {4{7'h7F}};
    model_reset();
    #12;
    check_reset_zero("reset");
    @(negedge clock);
    clear = 1'b1;

    // Steady 7654: evaluation on the 4th edge after the one that loads it.
    for (int i = 0; i < 4; i++) step(P7654, "t1_settle");
    chk("t1_locked_before", 32'(locked), 32'h0);
    step(P7654, "t1_eval");
    chk("t1_value", 32'(value), 32'h7654);
    chk("t1_locked", 32'(locked), 32'h1);
    chk("t1_update", 32'(update), 32'h1);
    step(P7654, "t1_after");
    chk("t1_update_pulse", 32'(update), 32'h0);
    for (int i = 0; i < 3; i++) step(P7654, "t1_hold");

    // Change HEX0 to 0.
    step(P7650, "t2_change");
    chk("t2_unlock", 32'(locked), 32'h0);
    chk("t2_value_hold", 32'(value), 32'h7654);
    for (int i = 0; i < 3; i++) step(P7650, "t2_settle");
    chk("t2_value_still", 32'(value), 32'h7654);
    step(P7650, "t2_eval");
    chk("t2_value", 32'(value), 32'h7650);
    chk("t2_update", 32'(update), 32'h1);
    step(P7650, "t2_after");

    // Blank HEX1 -> fault, then repair.
    for (int i = 0; i < 5; i++) step(PBLNK, "t3_blank");
    chk("t3_fault", 32'(fault), 32'h1);
    chk("t3_bad", 32'(bad_digit), 32'h2);
    chk("t3_value", 32'(value), 32'h7650);
    chk("t3_update", 32'(update), 32'h0);
    for (int i = 0; i < 5; i++) step(P7650, "t3_fix");
    chk("t3_relock", 32'(locked), 32'h1);
    chk("t3_bad_clr", 32'(bad_digit), 32'h0);

    // HEX2 toggling every 3 edges never evaluates.
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 3; i++) begin
        step((k % 2 == 0) ? P7250 : P7650, "t4_toggle");
        chk("t4_quiet", 32'({locked, fault, update}), 32'h0);
      end
    end
    for (int i = 0; i < 5; i++) step(P7250, "t4_settle");
    chk("t4_value", 32'(value), 32'h7250);
    chk("t4_update", 32'(update), 32'h1);

    // 2-edge glitch, same pattern re-presented.
    step(P7650, "t5_glitch");
    step(P7650, "t5_glitch");
    for (int i = 0; i < 5; i++) begin
      step(P7250, "t5_back");
      chk("t5_no_update", 32'(update), 32'h0);
    end
    chk("t5_relock", 32'(locked), 32'h1);
    chk("t5_value", 32'(value), 32'h7250);

    // Async clear mid-settle.
    step(P7654, "t6_pre");
    step(P7654, "t6_pre");
    #2 clear = 1'b0;
    #1 check_reset_zero("t6_mid");
    model_reset();
    @(negedge clock);
    clear = 1'b1;
    for (int i = 0; i < 5; i++) step(P7654, "t6_relock");
    chk("t6_first_update", 32'(update), 32'h1);
    // Async clear while locked.
    #2 clear = 1'b0;
    #1 check_reset_zero("t6_locked");
    model_reset();
    @(negedge clock);
    clear = 1'b1;
    for (int i = 0; i < 5; i++) step(P8888, "t6_8888");
    chk("t6_value", 32'(value), 32'h8888);
    chk("t6_update", 32'(update), 32'h1);

    // Randomized segments of random hold lengths.
    keep = P8888;
    for (int seg = 0; seg < 60; seg++) begin
      r = $urandom_range(0, 3);
      if (r == 0) pat = keep;
      else begin
        for (int d = 0; d < 4; d++) begin
          r = $urandom_range(0, 9);
          if (r == 0)      pat[7*d +: 7] = 7'h7F;
          else if (r == 1) pat[7*d +: 7] = 7'($urandom);
          else             pat[7*d +: 7] = seg_tab[$urandom_range(0, 15)];
        end
      end
      keep = pat;
      hold = $urandom_range(1, 7);
      for (int i = 0; i < hold; i++) step(pat, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
